// File: rtl/adc_link_if.sv
// Byte-level handshake bundle between adc_link_master and the uart_tx/uart_rx
// blocks plus the ADC mirror outputs.
interface adc_link_if;
    logic        enable;
    logic        start_tx;
    logic [7:0]  data_to_tx;
    logic        tx_busy;
    logic        rx_done;
    logic [7:0]  data_received;
    logic        parity_error;
    logic [11:0] adc_value;
    logic        value_valid;
    logic        linked;
    logic [7:0]  timeout_count;

    modport master (
        input  enable,
        input  tx_busy,
        input  rx_done,
        input  data_received,
        input  parity_error,
        output start_tx,
        output data_to_tx,
        output adc_value,
        output value_valid,
        output linked,
        output timeout_count
    );

    modport slave (
        output enable,
        output tx_busy,
        output rx_done,
        output data_received,
        output parity_error,
        input  start_tx,
        input  data_to_tx,
        input  adc_value,
        input  value_valid,
        input  linked,
        input  timeout_count
    );
endinterface

// File: rtl/adc_link_master.sv
// Main-side UART link master: ACK sync, periodic READ_ADC polling, timeout re-sync.
// Define ADC_LINK_PARITY_CHECK_EN to drop bytes flagged with a parity error.
module adc_link_master #(
    parameter int unsigned CLK_HZ      = 48000000,
    parameter int unsigned PERIOD_CYC  = 48000000,
    parameter int unsigned TIMEOUT_CYC = 480000,
    parameter logic [7:0]  ACK_BYTE    = 8'b00110011,
    parameter logic [7:0]  READ_BYTE   = 8'b10011011
) (
    input  logic          clk,
    input  logic          reset,
    adc_link_if.master    bus
);

    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SEND_SYNC   = 3'd1,
        S_WAIT_SYNC   = 3'd2,
        S_PERIOD_WAIT = 3'd3,
        S_SEND_READ   = 3'd4,
        S_WAIT_HI     = 3'd5,
        S_WAIT_LO     = 3'd6,
        S_TIMEOUT     = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] period_q, period_d;
    logic [3:0]  nibble_q, nibble_d;
    logic [7:0]  data_to_tx_q, data_to_tx_d;
    logic [11:0] adc_value_q, adc_value_d;
    logic        value_valid_q, value_valid_d;
    logic        linked_q, linked_d;
    logic [7:0]  timeout_count_q, timeout_count_d;

    logic        start_tx_s;
    logic        rx_ok_s;
    logic        rx_bad_s;
    logic        timer_expired_s;
    logic [31:0] unused_clk_hz_s;

    assign unused_clk_hz_s = 32'(CLK_HZ);

`ifdef ADC_LINK_PARITY_CHECK_EN
    assign rx_ok_s  = bus.rx_done & ~bus.parity_error;
    assign rx_bad_s = bus.rx_done &  bus.parity_error;
`else
    logic unused_parity_s;
    assign unused_parity_s = bus.parity_error;
    assign rx_ok_s         = bus.rx_done;
    assign rx_bad_s        = 1'b0;
`endif

    // The request is combinational so it can only ever rise in a non-busy cycle;
    // the byte itself is registered on entry to the send state.
    assign start_tx_s      = ((state_q == S_SEND_SYNC) || (state_q == S_SEND_READ)) && !bus.tx_busy;
    assign timer_expired_s = (timer_q == TIMEOUT_LAST);

    assign bus.start_tx      = start_tx_s;
    assign bus.data_to_tx    = data_to_tx_q;
    assign bus.adc_value     = adc_value_q;
    assign bus.value_valid   = value_valid_q;
    assign bus.linked        = linked_q;
    assign bus.timeout_count = timeout_count_q;

    // Next-state and datapath update for the link FSM.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q + 32'd1;
        period_d        = period_q;
        nibble_d        = nibble_q;
        data_to_tx_d    = data_to_tx_q;
        adc_value_d     = adc_value_q;
        value_valid_d   = 1'b0;
        linked_d        = linked_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            S_IDLE: begin
                timer_d  = 32'd0;
                period_d = 32'd0;
                if (bus.enable) begin
                    state_d      = S_SEND_SYNC;
                    data_to_tx_d = ACK_BYTE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND_SYNC: begin
                timer_d = 32'd0;
                if (start_tx_s) begin
                    state_d = S_WAIT_SYNC;
                end else begin
                    state_d = S_SEND_SYNC;
                end
            end

            S_WAIT_SYNC: begin
                if (rx_ok_s && (bus.data_received == ACK_BYTE)) begin
                    linked_d = 1'b1;
                    period_d = 32'd0;
                    state_d  = S_PERIOD_WAIT;
                end else if (timer_expired_s) begin
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = S_WAIT_SYNC;
                end
            end

            S_PERIOD_WAIT: begin
                timer_d = 32'd0;
                if (!bus.enable) begin
                    linked_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (period_q == PERIOD_LAST) begin
                    data_to_tx_d = READ_BYTE;
                    state_d      = S_SEND_READ;
                end else begin
                    period_d = period_q + 32'd1;
                end
            end

            S_SEND_READ: begin
                timer_d = 32'd0;
                if (start_tx_s) begin
                    state_d = S_WAIT_HI;
                end else begin
                    state_d = S_SEND_READ;
                end
            end

            S_WAIT_HI: begin
                if (rx_ok_s && (bus.data_received[7:4] == 4'hA)) begin
                    nibble_d = bus.data_received[3:0];
                    timer_d  = 32'd0;
                    state_d  = S_WAIT_LO;
                end else if (timer_expired_s) begin
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end

            S_WAIT_LO: begin
                // A corrupted low byte sends us back for a fresh high byte,
                // but the response deadline keeps running.
                if (rx_ok_s) begin
                    adc_value_d   = {nibble_q, bus.data_received};
                    value_valid_d = 1'b1;
                    period_d      = 32'd0;
                    state_d       = S_PERIOD_WAIT;
                end else if (timer_expired_s) begin
                    state_d = S_TIMEOUT;
                end else if (rx_bad_s) begin
                    nibble_d = 4'd0;
                    state_d  = S_WAIT_HI;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end

            S_TIMEOUT: begin
                linked_d = 1'b0;
                timer_d  = 32'd0;
                if (timeout_count_q != 8'hFF) begin
                    timeout_count_d = timeout_count_q + 8'd1;
                end else begin
                    timeout_count_d = timeout_count_q;
                end
                data_to_tx_d = ACK_BYTE;
                state_d      = S_SEND_SYNC;
            end

            default: begin
                timer_d  = 32'd0;
                linked_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            timer_q         <= 32'd0;
            period_q        <= 32'd0;
            nibble_q        <= 4'd0;
            data_to_tx_q    <= 8'd0;
            adc_value_q     <= 12'd0;
            value_valid_q   <= 1'b0;
            linked_q        <= 1'b0;
            timeout_count_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            period_q        <= period_d;
            nibble_q        <= nibble_d;
            data_to_tx_q    <= data_to_tx_d;
            adc_value_q     <= adc_value_d;
            value_valid_q   <= value_valid_d;
            linked_q        <= linked_d;
            timeout_count_q <= timeout_count_d;
        end
    end

endmodule

// File: tb/tb_adc_link_master.sv
// Randomized self-checking bench for adc_link_master with a short period/timeout.
module tb_adc_link_master;

    localparam int PERIOD = 1000;
    localparam int TMO    = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int checks = 0;
    int errors = 0;

    int         tx_cyc_q[$];
    logic [7:0] tx_byte_q[$];
    int         busy_viol = 0;
    int         vv_cnt    = 0;
    int         vv_cyc    = 0;

    logic [11:0] exp_adc = 12'd0;
    int          exp_tc  = 0;
    int          link_cyc = 0;
    int          last_read_cyc = 0;

    adc_link_if bus_if();

    adc_link_master #(
        .CLK_HZ      (48000000),
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TMO),
        .ACK_BYTE    (8'h33),
        .READ_BYTE   (8'h9B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction monitor: logs every transmit request and valid pulse.
    always @(negedge clk) begin
        if (bus_if.start_tx === 1'b1) begin
            tx_cyc_q.push_back(cyc);
            tx_byte_q.push_back(bus_if.data_to_tx);
            if (bus_if.tx_busy !== 1'b0) busy_viol++;
        end
        if (bus_if.value_valid === 1'b1) begin
            vv_cnt++;
            vv_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic perr);
        @(posedge clk);
        #1;
        bus_if.rx_done       = 1'b1;
        bus_if.data_received = b;
        bus_if.parity_error  = perr;
        @(posedge clk);
        #1;
        bus_if.rx_done       = 1'b0;
        bus_if.parity_error  = 1'b0;
        bus_if.data_received = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_tx(input logic [7:0] exp, input int bound, input string name, output int c);
        int n;
        logic [7:0] b;
        n = 0;
        c = -1;
        while (tx_byte_q.size() == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_byte_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no start_tx within %0d cycles, required byte 0x%02h", name, bound, exp);
        end else begin
            b = tx_byte_q.pop_front();
            c = tx_cyc_q.pop_front();
            if (b !== exp) begin
                errors++;
                $display("FAIL %s: tx byte 0x%02h, required 0x%02h", name, b, exp);
            end
        end
    endtask

    task automatic relink(input string name);
        logic [7:0] stray;
        tick($urandom_range(1, 40));
        stray = 8'($urandom_range(0, 255));
        if (stray == 8'h33) stray = 8'h34;
        send_rx(stray, 1'b0);
        checks++;
        if (bus_if.linked !== 1'b0) begin
            errors++;
            $display("FAIL %s_stray: linked=%b after non-ACK byte 0x%02h, required 0", name, bus_if.linked, stray);
        end
        send_rx(8'h33, 1'b0);
        link_cyc = cyc;
        checks++;
        if (bus_if.linked !== 1'b1) begin
            errors++;
            $display("FAIL %s_linked: linked=%b, required 1", name, bus_if.linked);
        end
    endtask

    task automatic do_read_round(input logic [7:0] hi, input logic [7:0] lo, input string name);
        int c, vc, vv0;
        logic [3:0] tg;
        tick($urandom_range(1, 30));
        tg = 4'($urandom_range(0, 15));
        if (tg == 4'hA) tg = 4'h5;
        send_rx({tg, 4'($urandom_range(0, 15))}, 1'b0);
        send_rx(hi, 1'b0);
        tick($urandom_range(0, 20));
        vv0 = vv_cnt;
        send_rx(lo, 1'b0);
        exp_adc = {hi[3:0], lo};
        vc = cyc;
        checks++;
        if (bus_if.adc_value !== exp_adc || bus_if.value_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_value: adc=0x%03h vv=%b, required adc=0x%03h vv=1", name, bus_if.adc_value, bus_if.value_valid, exp_adc);
        end
        tick(1);
        checks++;
        if (bus_if.value_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: value_valid=%b one cycle later, required 0", name, bus_if.value_valid);
        end
        wait_tx(8'h9B, PERIOD + 50, {name, "_next_read"}, c);
        checks++;
        if (c - vc != PERIOD) begin
            errors++;
            $display("FAIL %s_spacing: next read %0d cycles after update, required %0d", name, c - vc, PERIOD);
        end
        checks++;
        if (vv_cnt - vv0 != 1) begin
            errors++;
            $display("FAIL %s_vv_count: %0d value_valid pulses, required 1", name, vv_cnt - vv0);
        end
        last_read_cyc = c;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        reset = 1'b1;
        bus_if.enable        = 1'b0;
        bus_if.tx_busy       = 1'b0;
        bus_if.rx_done       = 1'b0;
        bus_if.data_received = 8'd0;
        bus_if.parity_error  = 1'b0;
        tick(4);
        obs = {bus_if.start_tx, bus_if.data_to_tx, bus_if.adc_value, bus_if.value_valid, bus_if.linked, bus_if.timeout_count};
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=0x%08h, required 0", obs);
        end
        checks++;
        if (tx_byte_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_tx: %0d transmits during reset, required 0", tx_byte_q.size());
        end
    endtask

    task automatic test_link_up();
        int c;
        bus_if.enable = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_tx(8'h33, 20, "link_sync", c);
        relink("link");
        checks++;
        if (tx_byte_q.size() != 0) begin
            errors++;
            $display("FAIL link_single_sync: %0d extra transmits, required 0", tx_byte_q.size());
        end
        wait_tx(8'h9B, PERIOD + 50, "link_first_read", c);
        checks++;
        if (c - link_cyc != PERIOD) begin
            errors++;
            $display("FAIL link_period: read %0d cycles after link, required %0d", c - link_cyc, PERIOD);
        end
        last_read_cyc = c;
    endtask

    task automatic test_reading();
        do_read_round(8'hA7, 8'h5C, "read_fixed");
        for (int i = 0; i < 2; i++) begin
            do_read_round({4'hA, 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 255)), "read_rand");
        end
    endtask

    task automatic test_timeout();
        int c;
        wait_tx(8'h33, TMO + 20, "timeout_resync", c);
        exp_tc++;
        checks++;
        if (c - last_read_cyc != TMO + 2) begin
            errors++;
            $display("FAIL timeout_timing: resync %0d cycles after read, required %0d", c - last_read_cyc, TMO + 2);
        end
        checks++;
        if (bus_if.linked !== 1'b0 || bus_if.timeout_count !== 8'(exp_tc) || bus_if.adc_value !== exp_adc) begin
            errors++;
            $display("FAIL timeout_state: linked=%b count=%0d adc=0x%03h, required linked=0 count=%0d adc=0x%03h",
                     bus_if.linked, bus_if.timeout_count, bus_if.adc_value, exp_tc, exp_adc);
        end
        relink("timeout_relink");
    endtask

    task automatic test_busy_hold();
        int c;
        tick(PERIOD - 1);
        bus_if.tx_busy = 1'b1;
        tick(31);
        bus_if.tx_busy = 1'b0;
        wait_tx(8'h9B, 10, "busy_read", c);
        checks++;
        if (c != link_cyc + PERIOD + 30) begin
            errors++;
            $display("FAIL busy_timing: read at +%0d cycles after link, required +%0d", c - link_cyc, PERIOD + 30);
        end
        tick(5);
        checks++;
        if (busy_viol != 0 || tx_byte_q.size() != 0) begin
            errors++;
            $display("FAIL busy_single: busy violations=%0d extra transmits=%0d, required 0 and 0", busy_viol, tx_byte_q.size());
        end
        last_read_cyc = c;
        do_read_round({4'hA, 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 255)), "busy_read");
    endtask

    task automatic test_parity();
        int c, vv0;
        tick($urandom_range(1, 10));
        vv0 = vv_cnt;
        send_rx(8'hA7, 1'b0);
        send_rx(8'h5C, 1'b1);
        send_rx(8'hA1, 1'b0);
        send_rx(8'h23, 1'b0);
`ifdef ADC_LINK_PARITY_CHECK_EN
        exp_adc = 12'h123;
`else
        exp_adc = 12'h75C;
`endif
        tick(3);
        checks++;
        if (bus_if.adc_value !== exp_adc || vv_cnt - vv0 != 1) begin
            errors++;
            $display("FAIL parity_value: adc=0x%03h pulses=%0d, required adc=0x%03h pulses=1",
                     bus_if.adc_value, vv_cnt - vv0, exp_adc);
        end
        wait_tx(8'h9B, PERIOD + 50, "parity_next_read", c);
        checks++;
        if (c - vv_cyc != PERIOD) begin
            errors++;
            $display("FAIL parity_spacing: read %0d cycles after update, required %0d", c - vv_cyc, PERIOD);
        end
    endtask

    task automatic test_async_reset();
        int c;
        logic [30:0] obs;
        tick(2);
        send_rx(8'hA5, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        exp_adc = 12'd0;
        exp_tc  = 0;
        obs = {bus_if.start_tx, bus_if.data_to_tx, bus_if.adc_value, bus_if.value_valid, bus_if.linked, bus_if.timeout_count};
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=0x%08h before any clock edge, required 0", obs);
        end
        tx_byte_q.delete();
        tx_cyc_q.delete();
        send_rx(8'h33, 1'b0);
        bus_if.enable = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(20);
        checks++;
        if (tx_byte_q.size() != 0 || bus_if.linked !== 1'b0 || bus_if.adc_value !== exp_adc) begin
            errors++;
            $display("FAIL async_idle: transmits=%0d linked=%b adc=0x%03h, required 0, 0, 0x000",
                     tx_byte_q.size(), bus_if.linked, bus_if.adc_value);
        end
        bus_if.enable = 1'b1;
        wait_tx(8'h33, 20, "async_resync", c);
        relink("async_relink");
        tick(10);
        bus_if.enable = 1'b0;
        tick(2);
        checks++;
        if (bus_if.linked !== 1'b0) begin
            errors++;
            $display("FAIL disable_unlink: linked=%b after enable low, required 0", bus_if.linked);
        end
        tx_byte_q.delete();
        tx_cyc_q.delete();
        tick(PERIOD + 50);
        checks++;
        if (tx_byte_q.size() != 0) begin
            errors++;
            $display("FAIL disable_parked: %0d transmits while disabled, required 0", tx_byte_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_reading();
        test_timeout();
        test_busy_hold();
        test_parity();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
